// File: rtl/minc_trace_fifo.sv
// Trace buffer for the minc core: captures each distinct (pc, acc) pair into a FWFT FIFO; MINC_TRACE_TS_EN adds a 16-bit timestamp.
// Entry visible one cycle after capture; rd_data held while rd_valid & !rd_ready; captures into a full FIFO are dropped and counted.
module minc_trace_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          CLK,
  input  logic          nRESET,
  input  logic [15:0]   pc_in,
  input  logic [7:0]    acc_in,
  input  logic          trace_en,
  input  logic          rd_ready,
  output logic          rd_valid,
`ifdef MINC_TRACE_TS_EN
  output logic [39:0]   rd_data,
`else
  output logic [23:0]   rd_data,
`endif
  output logic [AW:0]   level,
  output logic          ovf,
  output logic [7:0]    drop_cnt,
  input  logic          clr_ovf
);

  typedef struct packed {
    logic [15:0] pc;
    logic [7:0]  acc;
`ifdef MINC_TRACE_TS_EN
    logic [15:0] ts;
`endif
  } entry_t;

  typedef enum logic [1:0] {ST_OFF, ST_FIRST, ST_RUN} state_t;

  localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

  state_t        state;
  logic [15:0]   last_pc;
  logic [7:0]    last_acc;
  entry_t        mem [DEPTH];
  entry_t        wr_dat;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          pop;
  logic          cap_vld;
  logic          push;
  logic          drop;

`ifdef MINC_TRACE_TS_EN
  logic [15:0]   ts_cnt;

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) ts_cnt <= '0;
    else         ts_cnt <= ts_cnt + 16'd1;
  end

  assign wr_dat = '{pc: pc_in, acc: acc_in, ts: ts_cnt};
`else
  assign wr_dat = '{pc: pc_in, acc: acc_in};
`endif

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state <= ST_OFF;
    end else if (!trace_en) begin
      state <= ST_OFF;
    end else begin
      case (state)
        ST_OFF:   state <= ST_FIRST;
        ST_FIRST: state <= ST_RUN;
        default:  state <= ST_RUN;
      endcase
    end
  end

  // FIRST records the entry sample even if it matches the stale last_pc/last_acc.
  always_comb begin
    cap_vld = 1'b0;
    if (trace_en) begin
      if (state == ST_FIRST)
        cap_vld = 1'b1;
      else if (state == ST_RUN)
        cap_vld = ({pc_in, acc_in} != {last_pc, last_acc});
    end
  end

  assign rd_valid = (level != '0);
  assign full     = (level == FULL_LVL);
  assign pop      = rd_valid & rd_ready;
  assign push     = cap_vld & (~full | pop);
  assign drop     = cap_vld & full & ~pop;
  assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= wr_dat;
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      last_pc  <= '0;
      last_acc <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)
        level <= level + 1'b1;
      else if (pop && !push)
        level <= level - 1'b1;
      // Dropped captures still move the reference so a stalled consumer doesn't see repeats.
      if (cap_vld) begin
        last_pc  <= pc_in;
        last_acc <= acc_in;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      ovf      <= 1'b0;
      drop_cnt <= '0;
    end else if (clr_ovf) begin
      ovf      <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      ovf <= 1'b1;
      if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_minc_trace_fifo.sv
// Directed bench for minc_trace_fifo: reset, capture order, change filtering, overflow, full-with-pop, async reset.
module tb_minc_trace_fifo;
`ifdef MINC_TRACE_TS_EN
  localparam int DW = 40;
`else
  localparam int DW = 24;
`endif

  logic          CLK;
  logic          nRESET;
  logic [15:0]   pc_in;
  logic [7:0]    acc_in;
  logic          trace_en;
  logic          rd_ready;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic [4:0]    level;
  logic          ovf;
  logic [7:0]    drop_cnt;
  logic          clr_ovf;

  int n_checks = 0;
  int n_fail   = 0;

  minc_trace_fifo #(.DEPTH(16), .AW(4)) dut (
    .CLK      (CLK),
    .nRESET   (nRESET),
    .pc_in    (pc_in),
    .acc_in   (acc_in),
    .trace_en (trace_en),
    .rd_ready (rd_ready),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .level    (level),
    .ovf      (ovf),
    .drop_cnt (drop_cnt),
    .clr_ovf  (clr_ovf)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [23:0] head();
    return rd_data[DW-1 -: 24];
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    // 1: reset with random inputs
    nRESET = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pc_in    = 16'($urandom);
      acc_in   = 8'($urandom);
      trace_en = 1'($urandom);
      rd_ready = 1'($urandom);
      clr_ovf  = 1'($urandom);
      step();
    end
    check_eq("rst_rd_valid", rd_valid, 0);
    check_eq("rst_level", level, 0);
    check_eq("rst_ovf", ovf, 0);
    check_eq("rst_drop_cnt", drop_cnt, 0);
    check_eq("rst_rd_data", rd_data, 0);
    pc_in = 16'h0; acc_in = 8'h0; trace_en = 1'b0; rd_ready = 1'b0; clr_ovf = 1'b0;
    nRESET = 1'b1;
    step();

    // 2: sequential PCs, one per clock
    trace_en = 1'b1;
    step();
    check_eq("t2_first_no_cap", level, 0);
    for (int i = 0; i < 5; i++) begin
      pc_in = 16'(i);
      step();
      check_eq("t2_level", level, 64'(i + 1));
      check_eq("t2_head_stable", head(), 24'h000000);
    end
    rd_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check_eq("t2_valid", rd_valid, 1);
      check_eq("t2_order", head(), {16'(i), 8'h00});
      step();
    end
    check_eq("t2_empty", level, 0);
    check_eq("t2_data_zero", rd_data, 0);

    // 3: halt loop adds one entry; empty + capture + ready has no bypass
    pc_in = 16'h0010; acc_in = 8'h2A;
    step();
    check_eq("t3_no_bypass", level, 1);
    check_eq("t3_head", head(), 24'h00102A);
    rd_ready = 1'b0;
    for (int i = 0; i < 19; i++) step();
    check_eq("t3_halt_one", level, 1);
    acc_in = 8'h2B;
    step();
    check_eq("t3_acc_change", level, 2);
    rd_ready = 1'b1;
    check_eq("t3_pop0", head(), 24'h00102A);
    step();
    check_eq("t3_pop1", head(), 24'h00102B);
    step();
    rd_ready = 1'b0;
    check_eq("t3_empty", level, 0);

    // 4: overflow, clear-wins, saturation, drain
    for (int i = 0; i < 20; i++) begin
      pc_in = 16'h0100 + 16'(i); acc_in = 8'(i);
      step();
    end
    check_eq("t4_level", level, 16);
    check_eq("t4_ovf", ovf, 1);
    check_eq("t4_drop_cnt", drop_cnt, 4);
    check_eq("t4_head_held", head(), 24'h010000);
    pc_in = 16'h0114; acc_in = 8'h14; clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    check_eq("t4_clr_wins_ovf", ovf, 0);
    check_eq("t4_clr_wins_cnt", drop_cnt, 0);
    pc_in = 16'h0115; acc_in = 8'h15;
    step();
    check_eq("t4_redrop_cnt", drop_cnt, 1);
    acc_in = 8'h00;
    for (int i = 0; i < 260; i++) begin
      pc_in = 16'h1000 + 16'(i);
      step();
    end
    check_eq("t4_saturate", drop_cnt, 8'hFF);
    rd_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check_eq("t4_drain", head(), {16'h0100 + 16'(i), 8'(i)});
      step();
    end
    rd_ready = 1'b0;
    check_eq("t4_drained", level, 0);
    check_eq("t4_ovf_sticky", ovf, 1);
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    check_eq("t4_clr_ovf", ovf, 0);
    check_eq("t4_clr_cnt", drop_cnt, 0);

    // 5: full FIFO with simultaneous pop and capture
    acc_in = 8'h55;
    for (int i = 0; i < 16; i++) begin
      pc_in = 16'h0200 + 16'(i);
      step();
    end
    check_eq("t5_full", level, 16);
    rd_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check_eq("t5_head", head(), {16'h0200 + 16'(i), 8'h55});
      pc_in = 16'h0210 + 16'(i);
      step();
      check_eq("t5_level", level, 16);
    end
    check_eq("t5_no_drop", drop_cnt, 0);
    check_eq("t5_no_ovf", ovf, 0);
    for (int i = 0; i < 16; i++) begin
      check_eq("t5_drain", head(), {16'h0208 + 16'(i), 8'h55});
      step();
    end
    rd_ready = 1'b0;
    check_eq("t5_drained", level, 0);

    // 6: OFF holds the queue; async reset mid-cycle discards it
    acc_in = 8'h11;
    for (int i = 0; i < 7; i++) begin
      pc_in = 16'h0300 + 16'(i);
      step();
    end
    check_eq("t6_level7", level, 7);
    trace_en = 1'b0; pc_in = 16'h03FF;
    step();
    check_eq("t6_off_no_cap", level, 7);
    trace_en = 1'b1;
    #2;
    nRESET = 1'b0;
    #1;
    check_eq("t6_async_level", level, 0);
    check_eq("t6_async_valid", rd_valid, 0);
    step();
    nRESET = 1'b1;
    step();
    check_eq("t6_first_pending", level, 0);
    step();
    check_eq("t6_recapture", level, 1);
    check_eq("t6_head", head(), 24'h03FF11);
`ifdef MINC_TRACE_TS_EN
    check_eq("t6_ts_restart", rd_data[15:0], 16'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
